// File: rtl/pfu.sv
// Prefetch unit: issues sequential instruction fetches under a credit limit,
// queues responses with their PC and hands them to the decode stage in order.
`ifndef RV_SOFID_RANGE
`define RV_SOFID_RANGE 0:0
`endif

module pfu #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter int          DEPTH      = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   clk_en_i,
    input  logic                   exs_pc_wr_i,
    input  logic [31:0]            exs_pc_dout_i,
    input  logic                   ireqready_i,
    output logic                   ireqvalid_o,
    output logic [31:0]            ireqaddr_o,
    input  logic                   irspvalid_i,
    input  logic [31:0]            irspdata_i,
    input  logic                   irsperror_i,
    output logic                   pfu_dav_o,
    input  logic                   pfu_ack_i,
    output logic [`RV_SOFID_RANGE] pfu_sofid_o,
    output logic [31:0]            pfu_ins_o,
    output logic                   pfu_ferr_o,
    output logic [31:0]            pfu_pc_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0]   ONE   = CW'(1);
    localparam logic [PW-1:0]   PONE  = PW'(1);
    localparam logic [CW+1:0]   LIMIT = (CW+2)'(DEPTH);

    typedef logic [`RV_SOFID_RANGE] sofid_t;

    typedef struct packed {
        logic [31:0] ins;
        logic        ferr;
        logic [31:0] pc;
        sofid_t      sofid;
    } qent_t;

    logic [31:0]   fetch_pc;
    logic [CW-1:0] outst;
    logic [CW-1:0] outst_nxt;
    logic [CW-1:0] disc;
    logic [CW-1:0] count;
    logic [PW-1:0] q_rd;
    logic [PW-1:0] q_wr;
    logic [PW-1:0] a_rd;
    logic [PW-1:0] a_wr;
    logic          sofid_pend;

    qent_t         q_mem [DEPTH];
    logic [31:0]   a_mem [DEPTH];

    logic          redirect;
    logic          credit_ok;
    logic          req_fire;
    logic          rsp_fire;
    logic          q_push;
    logic          q_pop;
    logic [CW+1:0] in_flight;
    qent_t         new_ent;
    logic          unused_bits;

    assign unused_bits = ^exs_pc_dout_i[1:0];

    assign redirect = exs_pc_wr_i & clk_en_i;

    // Discarded transactions stay charged against the credit until they drain.
    assign in_flight = {2'b00, count} + {2'b00, outst} + {2'b00, disc};
    assign credit_ok = (in_flight < LIMIT);

    assign ireqvalid_o = clk_en_i & ~reset_i & ~exs_pc_wr_i & credit_ok;
    assign ireqaddr_o  = {fetch_pc[31:2], 2'b00};
    assign req_fire    = ireqvalid_o & ireqready_i;

    assign rsp_fire = irspvalid_i & clk_en_i & ~reset_i;
    assign q_push   = rsp_fire & ~redirect & (disc == '0);
    assign q_pop    = pfu_ack_i & (count != '0) & clk_en_i & ~redirect & ~reset_i;

    always_comb begin
        outst_nxt = outst;
        if (req_fire && !rsp_fire)
            outst_nxt = outst + ONE;
        else if (!req_fire && rsp_fire)
            outst_nxt = outst - ONE;
    end

    // Response PC comes from the request-address FIFO, popped on every
    // response whether kept or discarded, so it stays aligned with the bus.
    always_comb begin
        new_ent.ins   = irspdata_i;
        new_ent.ferr  = irsperror_i;
        new_ent.pc    = a_mem[a_rd];
        new_ent.sofid = sofid_t'(sofid_pend);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_pc   <= {RESET_ADDR[31:2], 2'b00};
            outst      <= '0;
            disc       <= '0;
            count      <= '0;
            q_rd       <= '0;
            q_wr       <= '0;
            a_rd       <= '0;
            a_wr       <= '0;
            sofid_pend <= 1'b1;
        end else if (clk_en_i) begin
            outst <= outst_nxt;
            if (req_fire) begin
                a_wr <= a_wr + PONE;
            end
            if (rsp_fire) begin
                a_rd <= a_rd + PONE;
            end

            if (redirect) begin
                fetch_pc   <= {exs_pc_dout_i[31:2], 2'b00};
                disc       <= outst_nxt;
                count      <= '0;
                q_rd       <= '0;
                q_wr       <= '0;
                sofid_pend <= 1'b1;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (rsp_fire && disc != '0) begin
                    disc <= disc - ONE;
                end
                if (q_push) begin
                    q_wr       <= q_wr + PONE;
                    sofid_pend <= 1'b0;
                end
                if (q_pop) begin
                    q_rd <= q_rd + PONE;
                end
                if (q_push && !q_pop)
                    count <= count + ONE;
                else if (!q_push && q_pop)
                    count <= count - ONE;
            end
        end
    end

    // Storage arrays carry no reset; validity is tracked by count/outst.
    always_ff @(posedge clk_i) begin
        if (q_push) begin
            q_mem[q_wr] <= new_ent;
        end
        if (req_fire) begin
            a_mem[a_wr] <= ireqaddr_o;
        end
    end

    assign pfu_dav_o   = (count != '0);
    assign pfu_ins_o   = q_mem[q_rd].ins;
    assign pfu_ferr_o  = q_mem[q_rd].ferr;
    assign pfu_pc_o    = q_mem[q_rd].pc;
    assign pfu_sofid_o = q_mem[q_rd].sofid;

endmodule
